// File: rtl/rv32v_dcache_responder.sv
// Direct-mapped data-cache responder for the vector memory stage: word-addressed backing
// store, tag array and fixed miss penalty. Define RV32V_DCACHE_STATS_EN for hit/miss counters.
module rv32v_dcache_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int NUM_LINES    = 16,
  parameter int LINE_WORDS   = 4,
  parameter int MISS_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic [3:0]  byte_ena,
  input  logic        flush,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        busy,
  output logic        req_err,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int DATA_W    = 32;
  localparam int WORD_BITS = $clog2(DEPTH_WORDS);
  localparam int OFF_BITS  = $clog2(LINE_WORDS);
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_LSB   = 2 + OFF_BITS + IDX_BITS;
  localparam int TAG_W     = 32 - TAG_LSB;
  localparam int CNT_W     = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_W-1:0]       tags [NUM_LINES];
  logic [DATA_W-1:0]      mem  [DEPTH_WORDS];

  logic [WORD_BITS-1:0]   word;
  logic [IDX_BITS-1:0]    line;
  logic [TAG_W-1:0]       tag;
  logic                   req, tag_hit, install, miss_det;

  assign word    = dmemaddr[2 +: WORD_BITS];
  assign line    = dmemaddr[2 + OFF_BITS +: IDX_BITS];
  assign tag     = dmemaddr[31:TAG_LSB];
  assign req     = ren ^ wen;
  assign req_err = ren & wen;
  assign tag_hit = valid[line] && (tags[line] == tag);
  assign busy    = (state != IDLE);
  assign dmemload = ren ? mem[word] : '0;

  // Control state: FSM, miss countdown and valid bits are the only reset flops.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (flush)
        valid <= '0;
      else if (install)
        valid[line] <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dhit     = 1'b0;
    install  = 1'b0;
    miss_det = 1'b0;
    if (flush) begin
      state_n = IDLE;
    end else if (!req_err) begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (tag_hit) begin
              dhit = 1'b1;
            end else begin
              state_n  = MISS;
              cnt_n    = CNT_W'(MISS_LATENCY - 1);
              miss_det = 1'b1;
            end
          end
        end
        MISS: begin
          if (!req)
            state_n = IDLE;
          else if (cnt == '0)
            state_n = FILL;
          else
            cnt_n = cnt - CNT_W'(1);
        end
        FILL: begin
          // A request dropped in FILL leaves the line uninstalled.
          state_n = IDLE;
          install = req;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Data-side storage carries no reset.
  always_ff @(posedge CLK) begin
    if (install)
      tags[line] <= tag;
    if (dhit && wen) begin
      for (int b = 0; b < 4; b++)
        if (byte_ena[b])
          mem[word][8*b +: 8] <= dmemstore[8*b +: 8];
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^dmemaddr[1:0];

`ifdef RV32V_DCACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Remembers that the request in flight already missed, so its final dhit is not a hit.
  logic req_missed;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_missed <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (miss_det)
        req_missed <= 1'b1;
      else if (dhit || !req)
        req_missed <= 1'b0;
      if (dhit && !req_missed)
        hit_count <= sat_inc(hit_count);
      if (miss_det)
        miss_count <= sat_inc(miss_count);
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;

  logic unused_miss_det;
  assign unused_miss_det = miss_det;
`endif

endmodule

// File: doc/rv32v_dcache_responder.md
Name: rv32v_dcache_responder

Overview:
- Responder end of the vector memory stage's data-cache request interface: accepts word-aligned read/write requests (ren/wen, dmemaddr, dmemstore, byte_ena) and returns dmemload/dhit.
- Direct-mapped tag model over a word-addressed backing store with a fixed miss penalty, so the address scheduler sees realistic hit and miss timing.
- Replaces the cache model in standalone vector-unit benches; it is the behavioural reference for dcache integration.

Parameters:
- DEPTH_WORDS, 1024, backing-store depth in 32-bit words (power of 2).
- NUM_LINES, 16, direct-mapped tag entries (power of 2).
- LINE_WORDS, 4, words per line (power of 2).
- MISS_LATENCY, 4, cycles spent in MISS before FILL (must be 1 or more).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ren  in  1  read request; held until dhit.
- wen  in  1  write request; held until dhit.
- dmemaddr  in  32  request address; bits [1:0] ignored.
- dmemstore  in  32  write data, lane-aligned.
- byte_ena  in  4  write lane enables; bit i selects dmemstore[8i+7:8i].
- flush  in  1  invalidate all tags (synchronous).
- dmemload  out  32  full read word; requester does lane extraction.
- dhit  out  1  request completes this cycle.
- busy  out  1  high in MISS or FILL.
- req_err  out  1  ren and wen both high this cycle.
- hit_count  out  32  hit counter (optional feature).
- miss_count  out  32  miss counter (optional feature).

Behaviour:
- Address decode:
  - word = dmemaddr[31:2] mod DEPTH_WORDS
  - line = (dmemaddr[31:2] / LINE_WORDS) mod NUM_LINES
  - tag = dmemaddr[31 : 2+log2(LINE_WORDS)+log2(NUM_LINES)]
- Reset:
  - State IDLE, all valid bits 0, counters 0.
  - dhit, busy and req_err are 0 while no request is present.
  - Backing-store contents are not reset.
- FSM IDLE / MISS / FILL:
  - IDLE, request valid and tag hit: dhit=1 combinationally, same cycle.
    - Write: at that edge, bytes with byte_ena=1 are updated; byte_ena=0000 writes nothing but still hits.
    - Read: dmemload = mem[word] in that cycle.
  - IDLE, request valid and miss: dhit=0; next state MISS, counter loaded with MISS_LATENCY-1.
  - MISS: counter decrements each cycle; at counter==0 next state FILL.
  - FILL: install valid=1 and tag for the line; next state IDLE. The held request then hits.
- Latency:
  - Hit: 0 cycles.
  - Cold miss: first dhit in cycle MISS_LATENCY+2 after the request is first seen.
- dmemload = mem[word] whenever ren=1 (write-after-write forwarding is not required); 0 when ren=0.
- Request dropped (ren=wen=0) during MISS: return to IDLE next cycle, no install.
- Address changes during MISS/FILL: FILL installs the tag of the address present in FILL cycle; requester must hold stable (bench asserts).
- flush:
  - Clears all valid bits at the edge; dhit forced 0 that cycle.
  - In MISS/FILL, aborts to IDLE with no install.
  - Flush has priority over FILL install.
- ren & wen both 1: req_err=1, request ignored, dhit=0, state unchanged.
- Back-to-back requests: a new request may be presented in the cycle after dhit; no bubble is required on a hit.
- Reset mid-MISS: immediate return to IDLE, valids cleared.

Optional Feature:
- Macro: RV32V_DCACHE_STATS_EN.
- Defined:
  - hit_count increments on each dhit cycle with no preceding miss for that request.
  - miss_count increments on each IDLE miss detection.
  - Both saturate at 32'hFFFF_FFFF and are cleared by reset only.
- Not defined: hit_count and miss_count tied to 0; no counter flops.

Test Plan:
- Cold read, reset, MISS_LATENCY=4, ren=1, addr 0x100 held -> dhit low in cycles 0-5, high in cycle 6 with dmemload = preloaded word; busy high in cycles 1-5.
- Write 0x100, byte_ena=0011, data 0xAABBCCDD, prior word 0x11223344, line already valid -> dhit same cycle; readback 0x1122CCDD.
- Line reuse: read 0x104 after 0x100 is filled (same line, LINE_WORDS=4) -> dhit in cycle 0; read 0x500 (same line index, different tag) -> miss, dhit in cycle 6.
- flush in cycle 2 of a miss on 0x200 -> state IDLE in cycle 3, no install; the held request restarts its miss and dhit arrives 6 cycles after restart.
- ren=wen=1 at 0x0 -> req_err=1, dhit=0, memory unchanged, no counter increment.
- Stats with RV32V_DCACHE_STATS_EN: 1 cold miss then 3 hits -> miss_count=1, hit_count=3; without the macro both read 0.
